// File: rtl/pulse_driver.sv
// pulse_driver: turns one {CmdCnt0, CmdCnt1} command into CmdCnt0 plain En pulses
// followed by GROUP*CmdCnt1 Slt=1 pulses, then a one-cycle Done. Option macro: PULSE_GAP_EN.
module pulse_driver #(
   parameter int W     = 16,
   parameter int GROUP = 4
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         CmdValid,
   output logic         CmdReady,
   input  logic [W-1:0] CmdCnt0,
   input  logic [W-1:0] CmdCnt1,
   output logic         En,
   output logic         Slt,
   output logic         Busy,
   output logic         Done,
   output logic [1:0]   DbgState
);

   // Sized so GROUP*CmdCnt1 never truncates, even for an all-ones CmdCnt1.
   localparam int CW = W + $clog2(GROUP);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND0 = 2'd1,
      SEND1 = 2'd2,
      FIN   = 2'd3
   } state_t;

   state_t        state = IDLE;
   state_t        state_nxt;
   logic [W-1:0]  rem0 = '0;
   logic [W-1:0]  rem0_nxt;
   logic [CW-1:0] rem1 = '0;
   logic [CW-1:0] rem1_nxt;
   logic          en_q   = 1'b0;
   logic          slt_q  = 1'b0;
   logic          busy_q = 1'b0;
   logic          done_q = 1'b0;
   logic          step;
   logic          pause_nxt;
   logic          send_nxt;

   // step: this cycle ends one pulse slot; pause_nxt: next cycle is an En=0 gap.
`ifdef PULSE_GAP_EN
   logic gap = 1'b0;
   logic gap_nxt;

   always_comb begin
      gap_nxt = ((state == SEND0) || (state == SEND1)) && !gap;
   end

   always_ff @(posedge Clk) begin
      if (Reset) gap <= 1'b0;
      else       gap <= gap_nxt;
   end

   assign step      = gap;
   assign pause_nxt = gap_nxt;
`else
   assign step      = 1'b1;
   assign pause_nxt = 1'b0;
`endif

   // Handshake: a command is taken on a posedge where CmdValid && CmdReady;
   // CmdReady is high only in IDLE and CmdValid alone never changes state.
   always_comb begin
      state_nxt = state;
      rem0_nxt  = rem0;
      rem1_nxt  = rem1;
      case (state)
         IDLE: begin
            if (CmdValid) begin
               rem0_nxt = CmdCnt0;
               rem1_nxt = CW'(CmdCnt1) * CW'(GROUP);
               if (CmdCnt0 != '0)      state_nxt = SEND0;
               else if (CmdCnt1 != '0) state_nxt = SEND1;
               else                    state_nxt = FIN;
            end
         end
         SEND0: begin
            if (step) begin
               if (rem0 == W'(1)) begin
                  rem0_nxt  = '0;
                  state_nxt = (rem1 != '0) ? SEND1 : FIN;
               end else begin
                  rem0_nxt = rem0 - W'(1);
               end
            end
         end
         SEND1: begin
            if (step) begin
               if (rem1 == CW'(1)) begin
                  rem1_nxt  = '0;
                  state_nxt = FIN;
               end else begin
                  rem1_nxt = rem1 - CW'(1);
               end
            end
         end
         FIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign send_nxt = (state_nxt == SEND0) || (state_nxt == SEND1);

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state  <= IDLE;
         rem0   <= '0;
         rem1   <= '0;
         en_q   <= 1'b0;
         slt_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         rem0   <= rem0_nxt;
         rem1   <= rem1_nxt;
         en_q   <= send_nxt && !pause_nxt;
         slt_q  <= (state_nxt == SEND1) && !pause_nxt;
         busy_q <= (state_nxt != IDLE);
         done_q <= (state_nxt == FIN);
      end
   end

   assign CmdReady = (state == IDLE);
   assign En       = en_q;
   assign Slt      = slt_q;
   assign Busy     = busy_q;
   assign Done     = done_q;
   assign DbgState = state;

endmodule

// File: tb/tb_pulse_driver.sv
// tb_pulse_driver: per-cycle scoreboard of expected {En,Slt,Busy,Done} built from the
// command rules, plus a table of commands with hand-computed pulse counts and durations.
module tb_pulse_driver;

   localparam int TW = 6;
   localparam int TG = 4;

   logic          Clk = 1'b0;
   logic          Reset = 1'b0;
   logic          CmdValid = 1'b0;
   logic          CmdReady;
   logic [TW-1:0] CmdCnt0 = '0;
   logic [TW-1:0] CmdCnt1 = '0;
   logic          En, Slt, Busy, Done;
   logic [1:0]    DbgState;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected outputs per future cycle, {En, Slt, Busy, Done}; empty means IDLE.
   logic [3:0] exp_q[$];

   typedef struct {
      logic [TW-1:0] c0;
      logic [TW-1:0] c1;
      int            p0;
      int            p1;
      int            dur;
   } vec_t;

   vec_t vecs[8];

   pulse_driver #(.W(TW), .GROUP(TG)) dut (
      .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
      .CmdCnt0(CmdCnt0), .CmdCnt1(CmdCnt1), .En(En), .Slt(Slt),
      .Busy(Busy), .Done(Done), .DbgState(DbgState)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string name);
      logic [4:0] exp, act;
      exp = (exp_q.size() > 0) ? {exp_q[0], 1'b0} : 5'b00001;
      act = {En, Slt, Busy, Done, CmdReady};
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t {En,Slt,Busy,Done,CmdReady} got %b expected %b",
                  name, $time, act, exp);
      end
   endtask

   task automatic push_cmd(input int n0, input int n1);
      for (int i = 0; i < n0; i++) begin
         exp_q.push_back(4'b1010);
`ifdef PULSE_GAP_EN
         exp_q.push_back(4'b0010);
`endif
      end
      for (int i = 0; i < n1 * TG; i++) begin
         exp_q.push_back(4'b1110);
`ifdef PULSE_GAP_EN
         exp_q.push_back(4'b0010);
`endif
      end
      exp_q.push_back(4'b0011);
   endtask

   // Drive one cycle of inputs, advance the model across the edge, then check.
   task automatic cycle(input logic rst, input logic v, input logic [TW-1:0] c0,
                        input logic [TW-1:0] c1, input string name);
      logic hs;
      Reset    = rst;
      CmdValid = v;
      CmdCnt0  = c0;
      CmdCnt1  = c1;
      hs = !rst && v && (exp_q.size() == 0);
      @(posedge Clk);
      if (rst) begin
         exp_q.delete();
      end else begin
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         if (hs) push_cmd(int'(c0), int'(c1));
      end
      #1;
      check(name);
   endtask

   task automatic run_vec(input vec_t t, input int idx);
      int  dur, n0, n1, exp_dur;
      logic seen;
      dur = 0; n0 = 0; n1 = 0; seen = 1'b0;
      cycle(1'b0, 1'b1, t.c0, t.c1, "vec_hs");
      for (int k = 0; k < 700 && !seen; k++) begin
         dur++;
         if (En && !Slt) n0++;
         if (En && Slt) n1++;
         if (Done) seen = 1'b1;
         else cycle(1'b0, 1'b0, TW'($urandom), TW'($urandom), "vec_run");
      end
`ifdef PULSE_GAP_EN
      exp_dur = 2 * (t.p0 + t.p1) + 1;
`else
      exp_dur = t.dur;
`endif
      n_tests++;
      if (!seen || n0 != t.p0 || n1 != t.p1 || dur != exp_dur) begin
         n_fail++;
         $display("FAIL vec%0d c0=%0d c1=%0d got done=%0b p0=%0d p1=%0d dur=%0d expected p0=%0d p1=%0d dur=%0d",
                  idx, t.c0, t.c1, seen, n0, n1, dur, t.p0, t.p1, exp_dur);
      end
      n_tests++;
      if (seen && (n1 / TG) != int'(t.c1)) begin
         n_fail++;
         $display("FAIL vec%0d output1 units got %0d expected %0d", idx, n1 / TG, t.c1);
      end
      cycle(1'b0, 1'b0, '0, '0, "vec_idle");
   endtask

   initial begin
      vecs[0] = '{c0: 6'd3,  c1: 6'd0,  p0: 3,  p1: 0,   dur: 4};
      vecs[1] = '{c0: 6'd2,  c1: 6'd2,  p0: 2,  p1: 8,   dur: 11};
      vecs[2] = '{c0: 6'd0,  c1: 6'd0,  p0: 0,  p1: 0,   dur: 1};
      vecs[3] = '{c0: 6'd0,  c1: 6'd1,  p0: 0,  p1: 4,   dur: 5};
      vecs[4] = '{c0: 6'd1,  c1: 6'd0,  p0: 1,  p1: 0,   dur: 2};
      vecs[5] = '{c0: 6'd63, c1: 6'd0,  p0: 63, p1: 0,   dur: 64};
      vecs[6] = '{c0: 6'd0,  c1: 6'd63, p0: 0,  p1: 252, dur: 253};
      vecs[7] = '{c0: 6'd5,  c1: 6'd3,  p0: 5,  p1: 12,  dur: 18};

      #1;
      check("pre_reset");
      cycle(1'b1, 1'b0, '0, '0, "reset");
      cycle(1'b1, 1'b1, 6'd3, 6'd3, "reset_hs");
      cycle(1'b0, 1'b0, '0, '0, "after_reset");

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Reset during the third Slt pulse of a CmdCnt1=1 command.
      cycle(1'b0, 1'b1, 6'd0, 6'd1, "abort_hs");
      cycle(1'b0, 1'b0, '0, '0, "abort_p2");
`ifdef PULSE_GAP_EN
      cycle(1'b0, 1'b0, '0, '0, "abort_gap");
      cycle(1'b0, 1'b0, '0, '0, "abort_gap2");
`endif
      cycle(1'b0, 1'b0, '0, '0, "abort_p3");
      n_tests++;
      if (!(En && Slt)) begin
         n_fail++;
         $display("FAIL abort_setup En=%0b Slt=%0b expected 1 1", En, Slt);
      end
      cycle(1'b1, 1'b0, '0, '0, "abort_rst");
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, '0, '0, "abort_quiet");

      // CmdValid held high with changing counts: back-to-back acceptance.
      for (int i = 0; i < 80; i++)
         cycle(1'b0, 1'b1, TW'($urandom_range(0, 4)), TW'($urandom_range(0, 2)), "held_valid");

      for (int i = 0; i < 3000; i++) begin
         logic [TW-1:0] c0, c1;
         c0 = ($urandom_range(0, 39) == 0) ? 6'd63 : TW'($urandom_range(0, 6));
         c1 = ($urandom_range(0, 39) == 0) ? 6'd63 : TW'($urandom_range(0, 3));
         cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1), c0, c1, "random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pulse_driver.md
PULSE_DRIVER -- requirements
Module: pulse_driver

Interface
REQ-001 Parameter W, default 16, width of both command count fields.
REQ-002 Parameter GROUP, default 4, number of Slt pulses that make one Output1 unit.
REQ-003 Clk  input  1  sole clock; all state changes on posedge Clk.
REQ-004 Reset  input  1  synchronous, active-high reset, sampled on posedge Clk.
REQ-005 CmdValid  input  1  command present on CmdCnt0/CmdCnt1.
REQ-006 CmdReady  output  1  block can accept a command this cycle.
REQ-007 CmdCnt0  input  W  number of plain En pulses to emit (Slt=0).
REQ-008 CmdCnt1  input  W  number of Output1 units to emit; each unit is GROUP pulses with Slt=1.
REQ-009 En  output  1  registered enable pulse toward the counter.
REQ-010 Slt  output  1  registered select; meaningful only while En=1, else 0.
REQ-011 Busy  output  1  high from the cycle after command acceptance until Done.
REQ-012 Done  output  1  single-cycle pulse marking the end of a command.

Function
REQ-013 States: IDLE, SEND0, SEND1, FIN; the block SHALL implement exactly these.
REQ-014 CmdReady = 1 only in IDLE; a handshake occurs when CmdValid && CmdReady at posedge Clk, capturing both counts.
REQ-015 On handshake: next state SEND0 if CmdCnt0 != 0; else SEND1 if CmdCnt1 != 0; else FIN.
REQ-016 SEND0: En=1, Slt=0 for exactly CmdCnt0 consecutive cycles; then SEND1 if CmdCnt1 != 0, else FIN.
REQ-017 SEND1: En=1, Slt=1 for exactly CmdCnt1*GROUP consecutive cycles; then FIN.
REQ-018 Internal SEND1 down-counter SHALL be W+clog2(GROUP) bits wide; no truncation for CmdCnt1 = 2^W-1.
REQ-019 FIN: En=0, Slt=0, Done=1 for one cycle; next state IDLE.
REQ-020 First En pulse appears in the cycle immediately after the handshake cycle (1-cycle latency).
REQ-021 Busy = 1 in SEND0, SEND1, FIN; 0 in IDLE.
REQ-022 In IDLE: En=0, Slt=0, Done=0; CmdValid changes outside a handshake have no effect.
REQ-023 Inputs CmdCnt0/CmdCnt1 changing after handshake SHALL NOT affect the running command.
REQ-024 Back-to-back commands: next handshake possible earliest in the cycle after FIN (IDLE cycle), no overlap.

Reset
REQ-025 Reset=1 at posedge Clk: state IDLE, En=0, Slt=0, Done=0, Busy=0, CmdReady=1 on the next cycle, counters cleared.
REQ-026 Reset mid-command SHALL abort it without Done; Reset has priority over a simultaneous handshake, which is discarded.
REQ-027 Initial (pre-reset) register values SHALL equal reset values.

Configuration
REQ-028 Macro PULSE_GAP_EN: when defined, every En=1 cycle in SEND0/SEND1 is followed by one En=0, Slt=0 gap cycle (the last pulse's gap precedes FIN); pulse counts unchanged.
REQ-029 Without PULSE_GAP_EN pulses are back-to-back per REQ-016/017; command duration = CmdCnt0 + GROUP*CmdCnt1 + 1 cycles.

Verification
REQ-030 Reset, then CmdCnt0=3, CmdCnt1=0 handshake -> En=1,Slt=0 for 3 cycles starting next cycle, Done at cycle 4, CmdReady back at cycle 5.
REQ-031 CmdCnt0=2, CmdCnt1=2 -> 2 pulses Slt=0 then 8 pulses Slt=1 contiguous, Done one cycle after; counter model reads Output0=2, Output1=2.
REQ-032 CmdCnt0=0, CmdCnt1=0 -> no En pulses, Done in the cycle after handshake.
REQ-033 Reset asserted during 3rd SEND1 pulse of CmdCnt1=1 -> En=0 next cycle, no Done, CmdReady=1, Busy=0.
REQ-034 PULSE_GAP_EN defined, CmdCnt0=2, CmdCnt1=1 -> En pattern 1,0,1,0 (Slt=0) then 1,0,1,0,1,0,1,0 (Slt=1), then Done.
REQ-035 CmdValid held high with changing counts during a command -> only the captured command runs; the next is accepted in the first IDLE cycle.
